// File: rtl/rv32_pkg.sv
// Shared rv32 core types and constants used by the fetch stage and its FIFO.
package rv32_pkg;

    typedef logic [31:0] rv32_word;
    typedef logic [31:0] instr_t;

    // Canonical no-op: addi x0, x0, 0.
    localparam instr_t   RV32_NOP      = 32'h0000_0013;
    localparam rv32_word RV32_RESET_PC = 32'h0000_0000;

    // One buffered fetch result: the instruction word and the address it came from.
    typedef struct packed {
        instr_t   instr;
        rv32_word pc;
    } fetch_entry_t;

    // Force a byte address onto a word boundary.
    function automatic rv32_word word_align(input rv32_word addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/rv32_fetch_fifo.sv
// Small synchronous FIFO holding fetched {instr, pc} pairs between memory and decode.
module rv32_fetch_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointer, occupancy and storage update; flush empties the queue in one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: all state here uses non-blocking assignment so every flop samples pre-edge values.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: storage is reset as well, so the head reads zero out of reset and no pre-reset word can ever reach decode.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/rv32_fetch_unit.sv
// rv32 instruction fetch: owns the PC, issues credit-limited word reads,
// buffers responses with their PCs and hands them to decode; redirect flushes.
module rv32_fetch_unit
    import rv32_pkg::*;
#(
    parameter rv32_word RESET_PC = RV32_RESET_PC,
    parameter int       DEPTH    = 2
) (
    input  logic     clk,
    input  logic     resetn,
    output logic     imem_req_valid,
    input  logic     imem_req_ready,
    output rv32_word imem_req_addr,
    input  logic     imem_rsp_valid,
    input  instr_t   imem_rsp_data,
    input  logic     redirect_valid,
    input  rv32_word redirect_pc,
    output logic     out_valid,
    input  logic     out_ready,
    output instr_t   out_instr,
    output rv32_word out_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    rv32_word         pc_q;
    rv32_word         rsp_pc_q;
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W-1:0] drop_q;
    logic             started_q;

    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_used;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;
    logic             req_fire;
    logic             rsp_keep;
    logic             fifo_pop;
    rv32_word         redirect_target;

    // Every slot is either outstanding in memory or sitting in the FIFO, so
    // limiting their sum to DEPTH means a response always has room to land.
    assign credit_used     = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req_valid  = started_q && !redirect_valid && (credit_used < (CNT_W + 1)'(DEPTH));
    assign imem_req_addr   = pc_q;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign redirect_target = word_align(redirect_pc);

    // Responses owed to a flushed stream are counted off by drop_q and never buffered.
    assign rsp_keep   = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc_q};

    assign out_valid = (fifo_count != '0) && !redirect_valid;
    assign fifo_pop  = out_valid && out_ready;
    assign out_instr = fifo_head.instr;
    assign out_pc    = fifo_head.pc;

    // Outstanding count after this cycle's request and response; also the drop count on redirect.
    always_comb begin
        // NOTE: combinational logic uses blocking assignment and gives every output a default first, so no latch is inferred.
        outstanding_nxt = outstanding_q;
        if (req_fire) begin
            outstanding_nxt = outstanding_nxt + CNT_W'(1);
        end
        if (imem_rsp_valid && (outstanding_q != '0)) begin
            outstanding_nxt = outstanding_nxt - CNT_W'(1);
        end
    end

    // PC, response PC, drop counter and start-up flag; redirect overrides normal advance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            started_q     <= 1'b0;
        end else begin
            started_q     <= 1'b1;
            outstanding_q <= outstanding_nxt;
            if (redirect_valid) begin
                pc_q     <= redirect_target;
                rsp_pc_q <= redirect_target;
                drop_q   <= outstanding_nxt;
            end else begin
                if (req_fire) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (rsp_keep) begin
                    rsp_pc_q <= rsp_pc_q + 32'd4;
                end
                if (imem_rsp_valid && (drop_q != '0)) begin
                    drop_q <= drop_q - CNT_W'(1);
                end
            end
        end
    end

    rv32_fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Bench for rv32_fetch_unit: behavioural instruction memory with configurable
// latency and a scoreboard of expected {instr, pc} pairs fed by memory responses.
module tb_rv32_fetch_unit;
    import rv32_pkg::*;

    localparam int       DEPTH    = 2;
    localparam rv32_word RESET_PC = 32'h0000_0000;

    logic     clk = 1'b0;
    logic     resetn;
    logic     imem_req_valid;
    logic     imem_req_ready;
    rv32_word imem_req_addr;
    logic     imem_rsp_valid;
    instr_t   imem_rsp_data;
    logic     redirect_valid;
    rv32_word redirect_pc;
    logic     out_valid;
    logic     out_ready;
    instr_t   out_instr;
    rv32_word out_pc;

    rv32_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        rv32_word addr;
        int       epoch;
        int       due;
    } pend_t;

    typedef struct {
        instr_t   instr;
        rv32_word pc;
    } exp_t;

    pend_t    pend_q[$];
    exp_t     exp_q[$];
    int       n_checks = 0;
    int       n_pass   = 0;
    int       cyc      = 0;
    int       epoch    = 0;
    int       mem_lat  = 1;
    int       n_out    = 0;
    rv32_word fetch_addr = RESET_PC;
    rv32_word last_out_pc = '0;
    logic     mem_rdy = 1'b1;
    logic     dec_rdy = 1'b1;
    logic     redir_req = 1'b0;
    rv32_word redir_target = '0;
    logic     obs_req_valid = 1'b0;
    logic     obs_out_valid = 1'b0;
    rv32_word obs_req_addr = '0;

    function automatic instr_t mem_word(input rv32_word a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    endtask

    // One clock: observe the DUT mid-cycle, then drive next-cycle inputs just after the edge.
    task automatic tick();
        exp_t  e;
        pend_t p;
        @(negedge clk);
        if (resetn) begin
            obs_req_valid = imem_req_valid;
            obs_req_addr  = imem_req_addr;
            obs_out_valid = out_valid;
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, fetch_addr);
                fetch_addr = fetch_addr + 32'd4;
                p.addr  = imem_req_addr;
                p.epoch = epoch;
                p.due   = cyc + mem_lat;
                pend_q.push_back(p);
            end
            if (out_valid && out_ready) begin
                check("out_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_instr", out_instr, e.instr);
                end
                n_out++;
                last_out_pc = out_pc;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        imem_req_ready = mem_rdy;
        out_ready      = dec_rdy;
        if (redir_req) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_target;
            epoch++;
            exp_q.delete();
            fetch_addr = redir_target & 32'hFFFF_FFFC;
            redir_req  = 1'b0;
        end else begin
            redirect_valid = 1'b0;
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            p = pend_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(p.addr);
            if (p.epoch == epoch) begin
                e.instr = mem_word(p.addr);
                e.pc    = p.addr;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_out(input string tag, input rv32_word want);
        int n0 = n_out;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (n_out != n0) break;
        end
        check({tag, "_seen"}, 32'(n_out != n0), 1);
        check(tag, last_out_pc, want);
    endtask

    // Stop issuing and let everything in flight reach decode.
    task automatic drain(input string tag);
        bit done = 1'b0;
        mem_rdy = 1'b0;
        dec_rdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (pend_q.size() == 0 && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, 32'(done), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 0);
        check({tag, "_req_addr"}, imem_req_addr, RESET_PC);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_instr"}, out_instr, 0);
        check({tag, "_out_pc"}, out_pc, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bit hit;
        rv32_word held_addr;

        resetn         = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        resetn         = 1'b1;

        // Streaming with 1-cycle memory and always-ready decode.
        mem_lat = 1;
        n0 = n_out;
        repeat (30) tick();
        check("stream_progress", 32'(n_out - n0 >= 10), 1);

        // Redirect latency: redirect at t, request t+1, response t+2, out_valid t+3.
        redir_target = 32'h0000_0040;
        redir_req    = 1'b1;
        tick();
        tick();
        check("lat_t_req_valid", 32'(obs_req_valid), 0);
        check("lat_t_out_valid", 32'(obs_out_valid), 0);
        tick();
        check("lat_t1_req_valid", 32'(obs_req_valid), 1);
        check("lat_t1_req_addr", obs_req_addr, 32'h0000_0040);
        tick();
        check("lat_t2_out_valid", 32'(obs_out_valid), 0);
        tick();
        check("lat_t3_out_valid", 32'(obs_out_valid), 1);
        check("lat_t3_out_pc", last_out_pc, 32'h0000_0040);

        // Decode backpressure: credit stops fetch at DEPTH, then in-order drain.
        dec_rdy = 1'b0;
        repeat (10) tick();
        check("bp_inflight", 32'(exp_q.size() + pend_q.size()), DEPTH);
        check("bp_req_valid", 32'(obs_req_valid), 0);
        check("bp_out_valid", 32'(obs_out_valid), 1);
        dec_rdy = 1'b1;
        repeat (10) tick();
        drain("bp_drain");

        // Redirect to a misaligned target with two requests outstanding.
        mem_lat = 4;
        mem_rdy = 1'b1;
        hit     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pend_q.size() == 2) begin
                hit = 1'b1;
                break;
            end
        end
        check("rd_two_outstanding", 32'(hit), 1);
        redir_target = 32'h0000_0103;
        redir_req    = 1'b1;
        tick();
        tick();
        check("rd_t_req_valid", 32'(obs_req_valid), 0);
        tick();
        check("rd_t1_req_addr", obs_req_addr, 32'h0000_0100);
        wait_out("rd_first_pc", 32'h0000_0100);
        drain("rd_drain");

        // Memory stall with a redirect in the middle of it.
        mem_lat = 1;
        tick();
        tick();
        check("st_req_valid", 32'(obs_req_valid), 1);
        check("st_req_addr", obs_req_addr, fetch_addr);
        held_addr = obs_req_addr;
        tick();
        check("st_addr_stable", obs_req_addr, held_addr);
        redir_target = 32'h0000_0200;
        redir_req    = 1'b1;
        tick();
        tick();
        check("st_redir_req_valid", 32'(obs_req_valid), 0);
        tick();
        check("st_new_req_valid", 32'(obs_req_valid), 1);
        check("st_new_req_addr", obs_req_addr, 32'h0000_0200);
        mem_rdy = 1'b1;
        wait_out("st_first_pc", 32'h0000_0200);
        repeat (8) tick();
        drain("st_drain");

        // PC wraps from the top of the address space to zero.
        mem_rdy      = 1'b1;
        redir_target = 32'hFFFF_FFFC;
        redir_req    = 1'b1;
        wait_out("wrap_top_pc", 32'hFFFF_FFFC);
        wait_out("wrap_zero_pc", 32'h0000_0000);
        drain("wrap_drain");

        // Asynchronous reset with a request in flight and data buffered.
        mem_lat = 3;
        mem_rdy = 1'b1;
        dec_rdy = 1'b0;
        hit     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pend_q.size() != 0 && exp_q.size() != 0) begin
                hit = 1'b1;
                break;
            end
        end
        check("ar_busy", 32'(hit), 1);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("ar");
        pend_q.delete();
        exp_q.delete();
        epoch++;
        fetch_addr     = RESET_PC;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn  = 1'b1;
        mem_lat = 1;
        dec_rdy = 1'b1;
        wait_out("ar_first_pc", RESET_PC);
        repeat (10) tick();
        drain("ar_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
